// File: rtl/disp_arb_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
//   Shared types for the seven-segment display arbiter.
//   W_VAL            : width of the binary value shown on the display
//   disp_val_t       : one display value
//   disp_arb_state_e : arbiter state (no owner / owned)
// ---------------------------------------------------------------------------
package disp_pkg;

  localparam int W_VAL = 14;

  typedef logic [W_VAL-1:0] disp_val_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } disp_arb_state_e;

endpackage

// File: rtl/disp_arb_if.sv
// ---------------------------------------------------------------------------
// disp_arb_if
//   Bundle between the display requesters and the arbiter.
//   i_req      : per-requester level request
//   i_val      : per-requester binary value
//   i_greeting : per-requester "show HI" flag
//   o_gnt      : one-hot current owner (zero when idle)
//   o_bin      : value forwarded to the display driver
//   o_greeting : greeting flag forwarded to the display driver
//   o_busy     : high while a grant is active
//   modport master : requester side, slave : arbiter side
// ---------------------------------------------------------------------------
interface disp_arb_if
  import disp_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int W     = W_VAL
) ();

  logic [N_REQ-1:0]        i_req;
  logic [N_REQ-1:0][W-1:0] i_val;
  logic [N_REQ-1:0]        i_greeting;
  logic [N_REQ-1:0]        o_gnt;
  logic [W-1:0]            o_bin;
  logic                    o_greeting;
  logic                    o_busy;

  modport master (
    output i_req, i_val, i_greeting,
    input  o_gnt, o_bin, o_greeting, o_busy
  );

  modport slave (
    input  i_req, i_val, i_greeting,
    output o_gnt, o_bin, o_greeting, o_busy
  );

endinterface

// File: rtl/disp_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotating priority encoder. Picks the first requester at or
//   after i_start (wrapping) whose bit is set in i_req and clear in i_excl.
//   i_req   : request vector
//   i_start : index that gets highest priority
//   i_excl  : mask of requesters that may not be picked
//   o_pick  : one-hot pick (zero when nothing eligible)
//   o_valid : at least one eligible requester
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  input  logic [N-1:0]  i_excl,
  output logic [N-1:0]  o_pick,
  output logic          o_valid
);

  logic [N-1:0] w_cand;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_rotPick;

  // Rotate the candidates so i_start lands on bit 0, isolate the lowest set
  // bit, then rotate the one-hot result back to absolute positions.
  always_comb begin
    w_cand    = i_req & ~i_excl;
    w_rot     = N'({w_cand, w_cand} >> i_start);
    w_rotPick = w_rot & (-w_rot);
    o_pick    = N'(({w_rotPick, w_rotPick} << i_start) >> N);
    o_valid   = |w_cand;
  end

endmodule

// File: rtl/disp_arb.sv
// ---------------------------------------------------------------------------
// disp_arb
//   Time-shares the four-digit display between N_REQ requesters. Requester 0
//   preempts everyone; the rest share under rotating priority with a minimum
//   hold of HOLD_CYC cycles whenever someone else is waiting.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : disp_arb_if slave (requests, values, grant and display outputs)
// ---------------------------------------------------------------------------
module disp_arb
  import disp_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int W       = W_VAL,
  parameter int CLK_HZ  = 100_000_000,
  parameter int HOLD_MS = 1000
) (
  input logic       i_clk,
  input logic       i_rst_n,
  disp_arb_if.slave bus
);

  localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
  localparam int TW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int IW       = $clog2(N_REQ);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  disp_arb_state_e r_state, w_nextState;
  logic [IW-1:0]    r_own, w_nextOwn;
  logic [IW-1:0]    r_rr, w_nextRr;
  logic [TW-1:0]    r_timer, w_nextTimer;
  logic [N_REQ-1:0] r_gnt, w_nextGnt;
  logic [W-1:0]     r_bin, w_nextBin;
  logic             r_greeting, w_nextGreeting;
  logic             r_busy, w_nextBusy;

  logic [N_REQ-1:0] w_pickGrant, w_pickRot;
  logic             w_validGrant, w_validRot;
  logic [IW-1:0]    w_idxGrant, w_idxRot;
  logic [IW-1:0]    w_startGrant;
  logic             w_change;

  // Requester 0 always wins a fresh pick, so starting the search at 0 when
  // it is requesting gives that priority without a separate path.
  assign w_startGrant = bus.i_req[0] ? '0 : r_rr;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pickGrant (
    .i_req   (bus.i_req),
    .i_start (w_startGrant),
    .i_excl  ('0),
    .o_pick  (w_pickGrant),
    .o_valid (w_validGrant)
  );

  // While owned, r_rr is the owner + 1 and the owner itself is masked, so
  // this yields the next other requester in rotation order.
  rr_pick #(.N(N_REQ), .IW(IW)) u_pickRot (
    .i_req   (bus.i_req),
    .i_start (r_rr),
    .i_excl  (r_gnt),
    .o_pick  (w_pickRot),
    .o_valid (w_validRot)
  );

  always_comb begin
    w_idxGrant = '0;
    w_idxRot   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pickGrant[i]) w_idxGrant = IW'(i);
      if (w_pickRot[i])   w_idxRot   = IW'(i);
    end
  end

  // State register plus the registered display outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_own      <= '0;
      r_rr       <= '0;
      r_timer    <= '0;
      r_gnt      <= '0;
      r_bin      <= '0;
      r_greeting <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_own      <= w_nextOwn;
      r_rr       <= w_nextRr;
      r_timer    <= w_nextTimer;
      r_gnt      <= w_nextGnt;
      r_bin      <= w_nextBin;
      r_greeting <= w_nextGreeting;
      r_busy     <= w_nextBusy;
    end
  end

  // Next owner: release, preempt, rotate-on-expiry, or keep, in that order.
  always_comb begin
    w_nextState = r_state;
    w_nextOwn   = r_own;
    w_nextTimer = r_timer;
    w_change    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_validGrant) begin
          w_nextState = OWN;
          w_nextOwn   = w_idxGrant;
          w_nextTimer = HOLD_LOAD;
          w_change    = 1'b1;
        end
      end
      OWN: begin
        if (!bus.i_req[r_own]) begin
          if (w_validGrant) begin
            w_nextOwn   = w_idxGrant;
            w_nextTimer = HOLD_LOAD;
            w_change    = 1'b1;
          end else begin
            w_nextState = IDLE;
            w_nextTimer = '0;
          end
        end else if (bus.i_req[0] && (r_own != '0)) begin
          w_nextOwn   = '0;
          w_nextTimer = HOLD_LOAD;
          w_change    = 1'b1;
        end else if ((r_timer == '0) && w_validRot) begin
          w_nextOwn   = w_idxRot;
          w_nextTimer = HOLD_LOAD;
          w_change    = 1'b1;
        end else if (r_timer != '0) begin
          w_nextTimer = r_timer - TW'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (w_change) begin
      w_nextRr = (w_nextOwn == LAST_IDX) ? '0 : w_nextOwn + IW'(1);
    end else begin
      w_nextRr = r_rr;
    end
  end

  // Display outputs follow the next owner's live inputs; idle shows HI.
  always_comb begin
    w_nextGnt      = '0;
    w_nextBin      = '0;
    w_nextGreeting = 1'b1;
    w_nextBusy     = 1'b0;
    if (w_nextState == OWN) begin
      w_nextGnt[w_nextOwn] = 1'b1;
      w_nextBin            = bus.i_val[w_nextOwn];
      w_nextGreeting       = bus.i_greeting[w_nextOwn];
      w_nextBusy           = 1'b1;
    end
  end

  assign bus.o_gnt      = r_gnt;
  assign bus.o_bin      = r_bin;
  assign bus.o_greeting = r_greeting;
  assign bus.o_busy     = r_busy;

endmodule

// File: tb/tb_disp_arb.sv
// ---------------------------------------------------------------------------
// tb_disp_arb
//   Self-checking bench for disp_arb with three requesters and a four-cycle
//   hold: directed vector table, async reset sequence, then random traffic
//   against a behavioural model of the sharing rules.
// ---------------------------------------------------------------------------
module tb_disp_arb;

  localparam int N        = 3;
  localparam int W        = 14;
  localparam int HOLD_CYC = 4;

  logic clk = 1'b0;
  logic rstN = 1'b1;

  disp_arb_if #(.N_REQ(N), .W(W)) bus ();

  disp_arb #(
    .N_REQ   (N),
    .W       (W),
    .CLK_HZ  (1000),
    .HOLD_MS (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic [W-1:0] tbVal [N];
  logic [N-1:0] tbGreet;

  // Model state: current owner (-1 = nobody), rotation start, and how many
  // cycles the current owner has been on screen.
  int mOwner;
  int mRr;
  int mHeld;

  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] val1;
    logic [N-1:0] expGnt;
    logic [W-1:0] expBin;
    logic         expGreet;
    logic         expBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic bit isSet(input logic [N-1:0] v, input int i);
    return ((v >> i) & 3'b001) != 3'b000;
  endfunction

  function automatic int choose(input logic [N-1:0] req, input int rr);
    if (isSet(req, 0)) return 0;
    for (int i = 0; i < N; i++) begin
      if (isSet(req, (rr + i) % N)) return (rr + i) % N;
    end
    return -1;
  endfunction

  task automatic grant(input int n);
    mOwner = n;
    mRr    = (n + 1) % N;
    mHeld  = 1;
  endtask

  task automatic modelReset();
    mOwner = -1;
    mRr    = 0;
    mHeld  = 0;
  endtask

  task automatic modelStep(input logic [N-1:0] req);
    int n;
    n = -1;
    if (mOwner >= 0 && isSet(req, mOwner) && (mOwner == 0 || !isSet(req, 0))) begin
      if (mHeld >= HOLD_CYC) begin
        for (int i = 1; i < N; i++) begin
          if (n < 0 && isSet(req, (mOwner + i) % N)) n = (mOwner + i) % N;
        end
      end
      if (n < 0) mHeld++;
      else grant(n);
    end else if (mOwner >= 0 && isSet(req, mOwner)) begin
      grant(0);
    end else begin
      n = choose(req, mRr);
      if (n >= 0) grant(n);
      else begin
        mOwner = -1;
        mHeld  = 0;
      end
    end
  endtask

  task automatic modelExpect(output logic [N-1:0] eGnt, output logic [W-1:0] eBin,
                             output logic eGreet, output logic eBusy);
    if (mOwner < 0) begin
      eGnt = '0; eBin = '0; eGreet = 1'b1; eBusy = 1'b0;
    end else begin
      eGnt   = 3'b001 << mOwner;
      eBin   = tbVal[mOwner];
      eGreet = isSet(tbGreet, mOwner);
      eBusy  = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [W-1:0] v0,
                               input logic [W-1:0] v1, input logic [W-1:0] v2,
                               input logic [N-1:0] greet);
    tbVal[0] = v0;
    tbVal[1] = v1;
    tbVal[2] = v2;
    tbGreet  = greet;
    bus.i_req      = req;
    bus.i_val      = {v2, v1, v0};
    bus.i_greeting = greet;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eGnt,
                             input logic [W-1:0] eBin, input logic eGreet,
                             input logic eBusy);
    nChecks++;
    if (bus.o_gnt !== eGnt || bus.o_bin !== eBin ||
        bus.o_greeting !== eGreet || bus.o_busy !== eBusy) begin
      nFails++;
      $display("[TB] FAIL %s: got gnt=%b bin=%0d greet=%b busy=%b, expected gnt=%b bin=%0d greet=%b busy=%b",
               name, bus.o_gnt, bus.o_bin, bus.o_greeting, bus.o_busy,
               eGnt, eBin, eGreet, eBusy);
    end
  endtask

  task automatic addVec(input logic [N-1:0] req, input logic [W-1:0] val1,
                        input logic [N-1:0] eGnt, input logic [W-1:0] eBin,
                        input logic eGreet, input logic eBusy);
    vec_t v;
    v.req = req; v.val1 = val1; v.expGnt = eGnt;
    v.expBin = eBin; v.expGreet = eGreet; v.expBusy = eBusy;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] eGnt;
    logic [W-1:0] eBin;
    logic         eGreet, eBusy;
    logic [N-1:0] rReq;

    // Directed table: requester 0 = 111, 2 = 222 (greeting set), 1 varies.
    addVec(3'b000, 14'd1234, 3'b000, 14'd0,    1'b1, 1'b0);
    addVec(3'b010, 14'd1234, 3'b010, 14'd1234, 1'b0, 1'b1);
    addVec(3'b010, 14'd999,  3'b010, 14'd999,  1'b0, 1'b1);
    addVec(3'b110, 14'd999,  3'b010, 14'd999,  1'b0, 1'b1);
    addVec(3'b110, 14'd999,  3'b010, 14'd999,  1'b0, 1'b1);
    for (int i = 0; i < 4; i++) addVec(3'b110, 14'd999, 3'b100, 14'd222, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) addVec(3'b110, 14'd999, 3'b010, 14'd999, 1'b0, 1'b1);
    addVec(3'b110, 14'd999,  3'b100, 14'd222,  1'b1, 1'b1);
    addVec(3'b110, 14'd999,  3'b100, 14'd222,  1'b1, 1'b1);
    addVec(3'b111, 14'd999,  3'b001, 14'd111,  1'b0, 1'b1);
    addVec(3'b111, 14'd999,  3'b001, 14'd111,  1'b0, 1'b1);
    addVec(3'b110, 14'd999,  3'b010, 14'd999,  1'b0, 1'b1);
    addVec(3'b010, 14'd999,  3'b010, 14'd999,  1'b0, 1'b1);
    addVec(3'b100, 14'd999,  3'b100, 14'd222,  1'b1, 1'b1);
    addVec(3'b000, 14'd999,  3'b000, 14'd0,    1'b1, 1'b0);
    for (int i = 0; i < 6; i++) addVec(3'b001, 14'd999, 3'b001, 14'd111, 1'b0, 1'b1);
    addVec(3'b011, 14'd999,  3'b010, 14'd999,  1'b0, 1'b1);
    addVec(3'b011, 14'd999,  3'b001, 14'd111,  1'b0, 1'b1);
    addVec(3'b000, 14'd999,  3'b000, 14'd0,    1'b1, 1'b0);

    applyStimulus(3'b000, 14'd111, 14'd1234, 14'd222, 3'b100);
    #1 rstN = 1'b0;
    #1 checkOutput("reset_async", 3'b000, 14'd0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_held", 3'b000, 14'd0, 1'b1, 1'b0);
    #2 rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, 14'd111, vecs[i].val1, 14'd222, 3'b100);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expBin,
                  vecs[i].expGreet, vecs[i].expBusy);
    end

    // Async reset while requester 2 owns, then regrant after release.
    applyStimulus(3'b100, 14'd111, 14'd999, 14'd222, 3'b100);
    step();
    checkOutput("rst_pre", 3'b100, 14'd222, 1'b1, 1'b1);
    #2 rstN = 1'b0;
    #1 checkOutput("rst_mid_cycle", 3'b000, 14'd0, 1'b1, 1'b0);
    step();
    checkOutput("rst_held_req", 3'b000, 14'd0, 1'b1, 1'b0);
    #2 rstN = 1'b1;
    #1 checkOutput("rst_released", 3'b000, 14'd0, 1'b1, 1'b0);
    step();
    checkOutput("rst_regrant", 3'b100, 14'd222, 1'b1, 1'b1);

    // Random traffic against the model.
    rstN = 1'b0;
    modelReset();
    applyStimulus(3'b000, 14'd0, 14'd0, 14'd0, 3'b000);
    step();
    #2 rstN = 1'b1;
    rReq = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rReq = 3'($urandom_range(0, 7));
      applyStimulus(rReq, 14'($urandom_range(0, 9999)), 14'($urandom_range(0, 9999)),
                    14'($urandom_range(0, 9999)), 3'($urandom_range(0, 7)));
      modelStep(rReq);
      step();
      modelExpect(eGnt, eBin, eGreet, eBusy);
      checkOutput($sformatf("rand%0d", c), eGnt, eBin, eGreet, eBusy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
